// File: rtl/stage_mem_access.sv
// ---------------------------------------------------------------------------
// stage_mem_access
//   MEM stage of the forwarding pipeline. Takes the EX result, issues
//   loads/stores on a request/ready data-memory port, passes ALU results
//   straight through, and presents a registered WB result + destination
//   register for the forwarding unit. Upstream is held (stall) while a memory
//   access is in flight.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined     : an access that sees no m_ready for TIMEOUT cycles is aborted
//                 (request dropped, err pulses, nothing retires).
//   Not defined : ACCESS waits indefinitely, err is tied 0, no TIMEOUT param.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ex_valid            EX/MEM latch holds a valid op
//   ex_aluOut, ex_B     ALU result / address, store data
//   ex_rd               destination register
//   memRead, memWrite   load / store flags (both set = store)
//   stall               hold upstream, high exactly while in ACCESS
//   m_read, m_write     memory requests (registered, held through ACCESS)
//   m_addr, m_wdata     memory address / write data (registered)
//   m_ready, m_rdata    memory completion strobe and load data
//   wb_valid            one-cycle retire pulse
//   wb_data, wb_rd      retired value / register, held until next retire
//   err                 one-cycle abort pulse (timeout build only)
//
// Handshake: a request is issued when m_read or m_write is high; it stays
// high with m_addr/m_wdata stable until the cycle m_ready is sampled high,
// and the request drops on the edge that samples it. m_ready is ignored
// while no request is outstanding.
// ---------------------------------------------------------------------------
module stage_mem_access #(
   parameter int WORD_SIZE = 16
`ifdef MEM_TIMEOUT_EN
   , parameter int TIMEOUT = 15
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic [WORD_SIZE-1:0] ex_aluOut,
   input  logic [WORD_SIZE-1:0] ex_B,
   input  logic [1:0]           ex_rd,
   input  logic                 memRead,
   input  logic                 memWrite,
   output logic                 stall,
   output logic                 m_read,
   output logic                 m_write,
   output logic [WORD_SIZE-1:0] m_addr,
   output logic [WORD_SIZE-1:0] m_wdata,
   input  logic                 m_ready,
   input  logic [WORD_SIZE-1:0] m_rdata,
   output logic                 wb_valid,
   output logic [WORD_SIZE-1:0] wb_data,
   output logic [1:0]           wb_rd,
   output logic                 err
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t                 state_q;
   logic                   m_read_q;
   logic                   m_write_q;
   logic [WORD_SIZE-1:0]   m_addr_q;
   logic [WORD_SIZE-1:0]   m_wdata_q;
   logic [1:0]             rd_q;
   logic                   wb_valid_q;
   logic [WORD_SIZE-1:0]   wb_data_q;
   logic [1:0]             wb_rd_q;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] cnt_q;
   logic          err_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         m_read_q   <= 1'b0;
         m_write_q  <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         rd_q       <= 2'd0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= 2'd0;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         wb_valid_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (ex_valid) begin
                  if (memRead || memWrite) begin
                     m_addr_q  <= ex_aluOut;
                     m_wdata_q <= ex_B;
                     rd_q      <= ex_rd;
                     // Write has priority when both flags are set.
                     m_write_q <= memWrite;
                     m_read_q  <= ~memWrite;
                     state_q   <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                     cnt_q     <= '0;
`endif
                  end else begin
                     wb_valid_q <= 1'b1;
                     wb_data_q  <= ex_aluOut;
                     wb_rd_q    <= ex_rd;
                  end
               end
            end
            ACCESS: begin
               // m_ready takes precedence over the timeout limit.
               if (m_ready) begin
                  m_read_q   <= 1'b0;
                  m_write_q  <= 1'b0;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= m_read_q ? m_rdata : m_addr_q;
                  wb_rd_q    <= rd_q;
                  state_q    <= IDLE;
               end
`ifdef MEM_TIMEOUT_EN
               // cnt_q counts completed ACCESS cycles; the edge ending the
               // TIMEOUT-th waiting cycle aborts.
               else if (cnt_q == CNT_LAST) begin
                  m_read_q  <= 1'b0;
                  m_write_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall    = (state_q == ACCESS);
   assign m_read   = m_read_q;
   assign m_write  = m_write_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign wb_valid = wb_valid_q;
   assign wb_data  = wb_data_q;
   assign wb_rd    = wb_rd_q;
`ifdef MEM_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule
